// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   state_e            : arbiter FSM encoding (IDLE, BUSY, RESPOND)
//   OWNER_CORE/INT     : values of the latched owner (match mux_selector)
//   TIMEOUT_READ_DATA  : read data returned when memory never responds
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_INT  = 1'b1;

    localparam logic [31:0] TIMEOUT_READ_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/memory_bus_arbiter_page_translator.sv
// Registered page relocation of a request address.
// When load_i is high, the register captures either
// address_i + (page_i << PAGE_SHIFT) (translate_i = 1) or address_i unchanged
// (translate_i = 0). The sum wraps modulo 2^BUS_WIDTH. The register holds its
// value until the next load, so it doubles as the latched request address.
//   clk, reset     : clock, asynchronous active-high reset
//   load_i         : capture a new address
//   translate_i    : apply the page base
//   address_i      : raw request address
//   page_i         : page number
//   address_o      : latched (translated) address
module memory_bus_arbiter_page_translator #(
    parameter int BUS_WIDTH  = 32,
    parameter int PAGE_SHIFT = 12,
    parameter int PAGE_BITS  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 translate_i,
    input  logic [BUS_WIDTH-1:0] address_i,
    input  logic [PAGE_BITS-1:0] page_i,
    output logic [BUS_WIDTH-1:0] address_o
);

    logic [BUS_WIDTH+PAGE_BITS-1:0] page_wide;
    logic [BUS_WIDTH-1:0]           page_base;
    logic [BUS_WIDTH-1:0]           address_d;
    logic [BUS_WIDTH-1:0]           address_q;

    always_comb begin
        // Widen before shifting so no page bits are lost ahead of truncation.
        page_wide = {{BUS_WIDTH{1'b0}}, page_i} << PAGE_SHIFT;
        page_base = page_wide[BUS_WIDTH-1:0];
        address_d = address_q;
        if (load_i) begin
            address_d = translate_i ? (address_i + page_base) : address_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q <= '0;
        end else begin
            address_q <= address_d;
        end
    end

    assign address_o = address_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter in front of the shared controller memory.
// The owner (mux_selector: 0 = core, 1 = interpreter) is sampled in IDLE; its
// request is latched, forwarded to memory in BUSY, and completed with a
// one-cycle response pulse in RESPOND. Core addresses are relocated by the
// page number; interpreter addresses pass through.
//
// Handshake: a master holds read/write high (level) until it sees its
// one-cycle response pulse, then drops it. Memory strobes stay high with
// stable address/data until mem_response is sampled high or the BUSY timeout
// expires; mem_response outside BUSY is ignored.
//
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   mux_selector, page_number       : owner select, core page
//   err_clear                       : clears timeout_error (IDLE only)
//   core_* / int_*                  : master request and response ports
//   mem_*                           : memory request and response ports
//   timeout_error                   : sticky timeout flag
//   dbg_state                       : current FSM state
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int PAGE_SHIFT     = 12,
    parameter int PAGE_BITS      = 20,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mux_selector,
    input  logic [PAGE_BITS-1:0] page_number,
    input  logic                 err_clear,
    input  logic                 core_read,
    input  logic                 core_write,
    input  logic [BUS_WIDTH-1:0] core_address,
    input  logic [BUS_WIDTH-1:0] core_write_data,
    output logic [BUS_WIDTH-1:0] core_read_data,
    output logic                 core_response,
    input  logic                 int_read,
    input  logic                 int_write,
    input  logic [BUS_WIDTH-1:0] int_address,
    input  logic [BUS_WIDTH-1:0] int_write_data,
    output logic [BUS_WIDTH-1:0] int_read_data,
    output logic                 int_response,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_write_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data,
    input  logic                 mem_response,
    output logic                 timeout_error,
    output logic [1:0]           dbg_state
);

    localparam logic [15:0]          TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] TIMEOUT_DATA = BUS_WIDTH'(TIMEOUT_READ_DATA);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 is_write_q, is_write_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]          count_q, count_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [BUS_WIDTH-1:0] core_rdata_q, core_rdata_d;
    logic [BUS_WIDTH-1:0] int_rdata_q, int_rdata_d;
    logic                 core_resp_q, core_resp_d;
    logic                 int_resp_q, int_resp_d;
    logic                 terr_q, terr_d;

    logic                 req_read;
    logic                 req_write;
    logic                 load;
    logic [BUS_WIDTH-1:0] req_address;
    logic [BUS_WIDTH-1:0] read_value;

    // Only the current owner's strobes are visible to the FSM.
    assign req_read    = mux_selector ? int_read    : core_read;
    assign req_write   = mux_selector ? int_write   : core_write;
    assign req_address = mux_selector ? int_address : core_address;

    memory_bus_arbiter_page_translator #(
        .BUS_WIDTH  (BUS_WIDTH),
        .PAGE_SHIFT (PAGE_SHIFT),
        .PAGE_BITS  (PAGE_BITS)
    ) u_page_translator (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .translate_i (mux_selector == OWNER_CORE),
        .address_i   (req_address),
        .page_i      (page_number),
        .address_o   (mem_address)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        is_write_d   = is_write_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        core_rdata_d = core_rdata_q;
        int_rdata_d  = int_rdata_q;
        terr_d       = terr_q;
        core_resp_d  = 1'b0;
        int_resp_d   = 1'b0;
        load         = 1'b0;
        read_value   = mem_response ? mem_read_data : TIMEOUT_DATA;

        case (state_q)
            ST_IDLE: begin
                if (err_clear) begin
                    terr_d = 1'b0;
                end
                if (req_read || req_write) begin
                    load        = 1'b1;
                    owner_d     = mux_selector;
                    // Write wins when both strobes are high.
                    is_write_d  = req_write;
                    wdata_d     = mux_selector ? int_write_data : core_write_data;
                    mem_write_d = req_write;
                    mem_read_d  = !req_write;
                    count_d     = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A response in the final counted cycle still completes normally.
                if (mem_response || (count_q == TIMEOUT_LAST)) begin
                    state_d     = ST_RESPOND;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    count_d     = '0;
                    core_resp_d = (owner_q == OWNER_CORE);
                    int_resp_d  = (owner_q == OWNER_INT);
                    if (!is_write_q) begin
                        if (owner_q == OWNER_CORE) begin
                            core_rdata_d = read_value;
                        end else begin
                            int_rdata_d = read_value;
                        end
                    end
                    if (!mem_response) begin
                        terr_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_CORE;
            is_write_q   <= 1'b0;
            wdata_q      <= '0;
            count_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            core_rdata_q <= '0;
            int_rdata_q  <= '0;
            core_resp_q  <= 1'b0;
            int_resp_q   <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            is_write_q   <= is_write_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            core_rdata_q <= core_rdata_d;
            int_rdata_q  <= int_rdata_d;
            core_resp_q  <= core_resp_d;
            int_resp_q   <= int_resp_d;
            terr_q       <= terr_d;
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = wdata_q;
    assign core_read_data = core_rdata_q;
    assign int_read_data  = int_rdata_q;
    assign core_response  = core_resp_q;
    assign int_response   = int_resp_q;
    assign timeout_error  = terr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        mux_selector;
    logic [19:0] page_number;
    logic        err_clear;
    logic        core_read, core_write;
    logic [31:0] core_address, core_write_data, core_read_data;
    logic        core_response;
    logic        int_read, int_write;
    logic [31:0] int_address, int_write_data, int_read_data;
    logic        int_response;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_response;
    logic        timeout_error;
    logic [1:0]  dbg_state;

    typedef struct packed {
        logic        port;      // 0 = core, 1 = interpreter
        logic        is_write;
        logic        mem_chk;   // memory model is expected to have served it
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // expected read_data register of that port
        logic        terr;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    int          mem_delay  = 1;
    logic        mem_enable = 1'b1;
    logic [31:0] mem_data_next = '0;
    int          seen = 0;
    int          cap_count = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wr, cap_rd;

    memory_bus_arbiter #(
        .BUS_WIDTH      (32),
        .PAGE_SHIFT     (12),
        .PAGE_BITS      (20),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mux_selector    (mux_selector),
        .page_number     (page_number),
        .err_clear       (err_clear),
        .core_read       (core_read),
        .core_write      (core_write),
        .core_address    (core_address),
        .core_write_data (core_write_data),
        .core_read_data  (core_read_data),
        .core_response   (core_response),
        .int_read        (int_read),
        .int_write       (int_write),
        .int_address     (int_address),
        .int_write_data  (int_write_data),
        .int_read_data   (int_read_data),
        .int_response    (int_response),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_response    (mem_response),
        .timeout_error   (timeout_error),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Responds mem_delay full cycles after it first sees a strobe; the
    // request seen at response time is captured for the monitor.
    always @(negedge clk) begin
        if (mem_response) begin
            mem_response = 1'b0;
            seen = 0;
        end else if ((mem_read || mem_write) && mem_enable && !reset) begin
            seen++;
            if (seen > mem_delay) begin
                mem_response  = 1'b1;
                mem_read_data = mem_data_next;
                cap_addr  = mem_address;
                cap_wdata = mem_write_data;
                cap_wr    = mem_write;
                cap_rd    = mem_read;
                cap_count++;
            end
        end else begin
            seen = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   mon_cap_count = 0;
    logic chk_low = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (chk_low) begin
            check("resp_one_cycle", 32'({core_response, int_response}), 32'd0);
            chk_low = 1'b0;
        end
        if (!reset && (core_response || int_response)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_response: core=%0b int=%0b with empty queue",
                         core_response, int_response);
            end else begin
                e = exp_q.pop_front();
                check("resp_port", 32'({core_response, int_response}),
                      e.port ? 32'd1 : 32'd2);
                check("read_data", e.port ? int_read_data : core_read_data, e.rdata);
                check("timeout_error", 32'(timeout_error), 32'(e.terr));
                if (e.mem_chk) begin
                    check("mem_served", 32'(cap_count), 32'(mon_cap_count + 1));
                    mon_cap_count = cap_count;
                    check("mem_op", 32'({cap_wr, cap_rd}), e.is_write ? 32'd2 : 32'd1);
                    check("mem_address", cap_addr, e.addr);
                    if (e.is_write) check("mem_write_data", cap_wdata, e.wdata);
                end
            end
            chk_low = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drop_all();
        core_read  = 1'b0;
        core_write = 1'b0;
        int_read   = 1'b0;
        int_write  = 1'b0;
    endtask

    task automatic start_req(input logic port, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        if (port) begin
            int_read = rd; int_write = wr; int_address = addr; int_write_data = wdata;
        end else begin
            core_read = rd; core_write = wr; core_address = addr; core_write_data = wdata;
        end
    endtask

    task automatic wait_resp(input logic port, output int lat);
        lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            lat++;
            if ((!port && core_response) || (port && int_response)) begin
                drop_all();
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_resp: no response on port %0d within 64 cycles", port);
        drop_all();
        lat = -1;
    endtask

    task automatic push(input logic port, input logic wr, input logic chk,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic terr);
        exp_t x;
        x.port = port; x.is_write = wr; x.mem_chk = chk; x.addr = addr;
        x.wdata = wdata; x.rdata = rdata; x.terr = terr;
        exp_q.push_back(x);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int strobe_cycles;

    initial begin
        reset = 1'b1;
        mux_selector = 1'b0; page_number = '0; err_clear = 1'b0;
        drop_all();
        core_address = '0; core_write_data = '0; int_address = '0; int_write_data = '0;
        mem_read_data = '0; mem_response = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_address", mem_address, 32'd0);
        check("reset_core_read_data", core_read_data, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_timeout_error", 32'(timeout_error), 32'd0);
        @(negedge clk) reset = 1'b0;

        // 1. core read with page 1
        mux_selector = 1'b0; page_number = 20'h00001; mem_data_next = 32'hCAFEBABE;
        push(1'b0, 1'b0, 1'b1, 32'h00001010, 32'h0, 32'hCAFEBABE, 1'b0);
        start_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_resp(1'b0, lat);
        check("core_read_latency", 32'(lat), 32'd3);

        // 2. interpreter write, page ignored
        mux_selector = 1'b1; page_number = 20'h000FF;
        push(1'b1, 1'b1, 1'b1, 32'h00002000, 32'h12345678, 32'h0, 1'b0);
        start_req(1'b1, 1'b0, 1'b1, 32'h2000, 32'h12345678);
        wait_resp(1'b1, lat);

        // 3a. non-owner request is ignored
        @(posedge clk); #1;
        mux_selector = 1'b0; mem_data_next = 32'hA5A50001;
        int_read = 1'b1; int_address = 32'h300;
        strobe_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_read || mem_write) strobe_cycles++;
        end
        check("non_owner_no_strobe", 32'(strobe_cycles), 32'd0);
        // 3b. ownership switch serves the waiting interpreter
        push(1'b1, 1'b0, 1'b1, 32'h00000300, 32'h0, 32'hA5A50001, 1'b0);
        mux_selector = 1'b1;
        wait_resp(1'b1, lat);
        // 3c. both strobes high: write wins, core_read_data unchanged
        mux_selector = 1'b0; page_number = 20'h0;
        push(1'b0, 1'b1, 1'b1, 32'h00000040, 32'h55AA55AA, 32'hCAFEBABE, 1'b0);
        start_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h55AA55AA);
        wait_resp(1'b0, lat);

        // 4. timeout
        mem_enable = 1'b0; page_number = 20'h00002;
        push(1'b0, 1'b0, 1'b0, 32'h00002008, 32'h0, 32'hDEADBEEF, 1'b1);
        start_req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        wait_resp(1'b0, lat);
        check("timeout_latency", 32'(lat), 32'd9);
        check("timeout_strobe_dropped", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        check("timeout_error_sticky", 32'(timeout_error), 32'd1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check("timeout_error_cleared", 32'(timeout_error), 32'd0);
        mem_enable = 1'b1;

        // 5. page wrap plus mid-flight mux/page changes
        mem_delay = 4; mux_selector = 1'b0; page_number = 20'hFFFFF;
        mem_data_next = 32'h0BADF00D;
        push(1'b0, 1'b0, 1'b1, 32'h00000234, 32'h0, 32'h0BADF00D, 1'b0);
        start_req(1'b0, 1'b1, 1'b0, 32'h1234, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wrap_busy_strobe", 32'(mem_read), 32'd1);
        check("wrap_busy_address", mem_address, 32'h00000234);
        mux_selector = 1'b1; page_number = 20'h00005;
        wait_resp(1'b0, lat);
        mux_selector = 1'b0; mem_delay = 1;

        // 6. reset while BUSY
        mem_enable = 1'b0; page_number = 20'h0;
        start_req(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_strobe", 32'(mem_read), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_mem_read", 32'(mem_read), 32'd0);
        check("reset_mid_mem_address", mem_address, 32'd0);
        check("reset_mid_core_read_data", core_read_data, 32'd0);
        check("reset_mid_state", 32'(dbg_state), 32'd0);
        drop_all();
        mem_enable = 1'b1;
        @(negedge clk) reset = 1'b0;
        page_number = 20'h00003; mem_data_next = 32'h600D600D;
        push(1'b0, 1'b0, 1'b1, 32'h00003060, 32'h0, 32'h600D600D, 1'b0);
        start_req(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
        wait_resp(1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd3);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
